// File: rtl/pipo_pkg.sv
// Shared encodings and defaults for the pipo shift register.
package pipo_pkg;

  localparam int PIPO_WIDTH = 16;

  typedef logic [1:0] sh_type_t;

  localparam sh_type_t SH_LSL = 2'b00;
  localparam sh_type_t SH_LSR = 2'b01;
  localparam sh_type_t SH_ASL = 2'b10;
  localparam sh_type_t SH_ASR = 2'b11;

endpackage

// File: rtl/pipo_shifter.sv
// Combinational fixed-distance shifter feeding the pipo load register.
module pipo_shifter
  import pipo_pkg::*;
#(
  parameter int WIDTH = PIPO_WIDTH,
  parameter int SHAMT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       shift_type,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = data;
    case (shift_type)
      SH_LSL, SH_ASL: shifted = data << SHAMT;
      SH_LSR:         shifted = data >> SHAMT;
      // Sign fill comes from treating the word as signed for the shift.
      SH_ASR:         shifted = $signed(data) >>> SHAMT;
      default:        shifted = data;
    endcase
  end

endmodule

// File: rtl/pipo.sv
// Parallel-in/parallel-out register that applies a one-step shift on load.
module pipo
  import pipo_pkg::*;
#(
  parameter int WIDTH = PIPO_WIDTH,
  parameter int SHAMT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  // Shift-type select; named shift_type because 'type' is a reserved word.
  input  logic [1:0]       shift_type,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] shifted;

  pipo_shifter #(
    .WIDTH (WIDTH),
    .SHAMT (SHAMT)
  ) u_shifter (
    .data       (data),
    .shift_type (shift_type),
    .shifted    (shifted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    data_out <= '0;
    else if (load) data_out <= shifted;
  end

endmodule

// File: tb/tb_pipo.sv
// Directed bench for pipo: reset, all shift types, hold, streaming loads, async reset.
module tb_pipo;
  import pipo_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic        load;
  logic [1:0]  shift_type;
  logic [15:0] data_out;
  logic [15:0] data_out0;

  int total = 0;
  int bad   = 0;

  pipo #(.WIDTH(16), .SHAMT(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .load       (load),
    .shift_type (shift_type),
    .data_out   (data_out)
  );

  // SHAMT=0 instance on the same inputs behaves as a plain register.
  pipo #(.WIDTH(16), .SHAMT(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .load       (load),
    .shift_type (shift_type),
    .data_out   (data_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] v_in  [4];
    logic [15:0] v_exp [4];
    v_in  = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    v_exp = '{16'h0002, 16'h0000, 16'hFFFE, 16'h0000};

    // reset dominates even with load high
    reset = 1'b0; data = 16'hACF1; load = 1'b1; shift_type = SH_LSL;
    #3;
    chk("rst_imm", data_out, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", data_out, 16'h0000);
    end
    load = 1'b0; reset = 1'b1;
    step(); chk("rel_noload0", data_out, 16'h0000);
    step(); chk("rel_noload1", data_out, 16'h0000);

    // logical shifts
    load = 1'b1; shift_type = SH_LSL;
    step(); chk("lsl", data_out, 16'h59E2);
    load = 1'b0;
    step(); chk("lsl_hold0", data_out, 16'h59E2);
    step(); chk("lsl_hold1", data_out, 16'h59E2);
    load = 1'b1; shift_type = SH_LSR;
    step(); chk("lsr", data_out, 16'h5678);
    load = 1'b0;

    // hold while data/type toggle
    for (int i = 0; i < 5; i++) begin
      data = ~data ^ 16'(i);
      shift_type = 2'(i);
      step(); chk("dc_hold", data_out, 16'h5678);
    end

    // arithmetic shifts
    data = 16'hACF1; load = 1'b1;
    shift_type = SH_ASL;
    step(); chk("asl", data_out, 16'h59E2);
    shift_type = SH_ASR;
    step(); chk("asr_neg", data_out, 16'hD678);
    chk("sh0_asr", data_out0, 16'hACF1);
    data = 16'h4000;
    step(); chk("asr_pos", data_out, 16'h2000);
    chk("sh0_pos", data_out0, 16'h4000);

    // streaming loads, no accumulation
    shift_type = SH_LSL;
    for (int i = 0; i < 4; i++) begin
      data = v_in[i];
      step(); chk("stream", data_out, v_exp[i]);
    end

    // async reset mid-run
    shift_type = SH_ASR; data = 16'h8000; load = 1'b1;
    step(); chk("asr_8000", data_out, 16'hC000);
    chk("sh0_8000", data_out0, 16'h8000);
    #3 reset = 1'b0;
    #1 chk("async_rst", data_out, 16'h0000);
    chk("async_rst0", data_out0, 16'h0000);
    step(); chk("rst_vs_load", data_out, 16'h0000);
    reset = 1'b1;
    step(); chk("post_rst", data_out, 16'hC000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
